// File: rtl/sprite_frame_sequencer_pkg.sv
// Sprite bus word layout, reserved component IDs and the sequencer state encoding.
package sprite_bus_pkg;

    localparam int COMP_MSB  = 31;
    localparam int COMP_LSB  = 26;
    localparam int CHILD_MSB = 25;
    localparam int CHILD_LSB = 21;
    localparam int ACT_MSB   = 20;
    localparam int ACT_LSB   = 17;
    localparam int TYPE_MSB  = 16;
    localparam int TYPE_LSB  = 14;
    localparam int TOG_BIT   = 13;
    localparam int DATA_MSB  = 12;
    localparam int DATA_LSB  = 0;

    localparam logic [5:0] COMMIT_ID  = 6'h3F;
    localparam logic [5:0] NULL_ID    = 6'h00;
    localparam logic [3:0] ACT_TOGGLE = 4'hF;
    localparam logic [3:0] ACT_UPDATE = 4'h1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        BCAST
    } seq_state_t;

    // Builds a bus word with the child field cleared.
    function automatic logic [31:0] make_word(input logic [5:0]  comp,
                                              input logic [3:0]  action,
                                              input logic [2:0]  wtype,
                                              input logic        tog,
                                              input logic [12:0] data);
        return {comp, 5'd0, action, wtype, tog, data};
    endfunction

endpackage

// File: rtl/sprite_frame_sequencer_fifo.sv
// Synchronous FIFO holding host command words. Head word is visible on rd_data
// whenever empty is low; a push is taken at full when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_pop   = rd_en && !empty;
    assign w_push  = wr_en && (!full || w_pop);
    assign rd_data = r_mem[r_rd_ptr];

    // Storage array; no reset needed since the count guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_frame_sequencer.sv
// Replays queued host words onto the sprite bus tagged with the back-buffer index,
// and turns a COMMIT word into a buffer-toggle broadcast at the next vblank start.
module sprite_frame_sequencer
    import sprite_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_IDS    = 16,
    parameter int V_ACTIVE   = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] writedata,
    output logic        front_buf,
    output logic [15:0] frame_count,
    output logic        commit_done
);
    seq_state_t  r_state;
    logic [5:0]  r_id;
    logic [31:0] r_writedata;
    logic        r_front_buf;
    logic [15:0] r_frame_count;
    logic        r_commit_done;

    logic [31:0] w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [5:0]  w_head_comp;
    logic [3:0]  w_head_act;
    logic        w_is_commit;
    logic        w_is_drop;
    logic        w_vb_start;
    logic        w_last_id;
    logic [31:0] w_bcast_word;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == IDLE) && !w_empty;

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (w_push),
        .wr_data(cmd_data),
        .rd_en  (w_pop),
        .rd_data(w_head),
        .full   (w_full),
        .empty  (w_empty)
    );

    assign w_head_comp  = w_head[COMP_MSB:COMP_LSB];
    assign w_head_act   = w_head[ACT_MSB:ACT_LSB];
    assign w_is_commit  = (w_head_comp == COMMIT_ID) && (w_head_act == ACT_TOGGLE);
    // Component 0 is the bus no-op and other 0x3F words are reserved, so neither is forwarded.
    assign w_is_drop    = (w_head_comp == NULL_ID) || (w_head_comp == COMMIT_ID);
    assign w_vb_start   = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
    assign w_last_id    = (r_id == 6'(NUM_IDS));
    assign w_bcast_word = make_word(r_id, ACT_TOGGLE, 3'd0, ~r_front_buf, 13'd0);

    // Sequencer FSM with registered bus word, buffer index and commit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_id          <= 6'd0;
            r_writedata   <= 32'h0;
            r_front_buf   <= 1'b0;
            r_frame_count <= 16'h0;
            r_commit_done <= 1'b0;
        end else begin
            r_writedata   <= 32'h0;
            r_commit_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        if (w_is_commit) begin
                            r_state <= WAIT_VB;
                        end else if (!w_is_drop) begin
                            r_writedata <= {w_head[COMP_MSB:TOG_BIT+1], ~r_front_buf,
                                            w_head[DATA_MSB:DATA_LSB]};
                        end
                    end
                end
                WAIT_VB: begin
                    if (w_vb_start) begin
                        r_id    <= 6'd1;
                        r_state <= BCAST;
                    end
                end
                BCAST: begin
                    r_writedata <= w_bcast_word;
                    r_id        <= r_id + 6'd1;
                    if (w_last_id) begin
                        r_front_buf   <= ~r_front_buf;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_commit_done <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign writedata   = r_writedata;
    assign front_buf   = r_front_buf;
    assign frame_count = r_frame_count;
    assign commit_done = r_commit_done;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Self-checking bench for sprite_frame_sequencer: vector table for plain words,
// hand sequences for commits, full FIFO and reset mid-broadcast.
module tb_sprite_frame_sequencer;
    import sprite_bus_pkg::*;

    localparam int NUM_IDS    = 16;
    localparam int FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = 32'h0;
    logic [9:0]  hcount = 10'd5;
    logic [9:0]  vcount = 10'd100;
    logic        cmd_ready;
    logic [31:0] writedata;
    logic        front_buf;
    logic [15:0] frame_count;
    logic        commit_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] exp;
        logic        emits;
    } vec_t;
    vec_t vecs[8];

    sprite_frame_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .NUM_IDS   (NUM_IDS),
        .V_ACTIVE  (480)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .hcount     (hcount),
        .vcount     (vcount),
        .writedata  (writedata),
        .front_buf  (front_buf),
        .frame_count(frame_count),
        .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] toggle_word(input int id, input logic tog);
        return make_word(6'(id), ACT_TOGGLE, 3'd0, tog, 13'd0);
    endfunction

    // Scoreboard: every non-idle bus word must be the next expected one.
    always @(negedge clk) begin
        if (!reset) begin
            if (writedata != 32'h0) begin
                if (exp_q.size() == 0) check("unexpected_word", writedata, 32'h0);
                else check("bus_word", writedata, exp_q.pop_front());
            end
            if (commit_done) begin
                n_pulses++;
                check("commit_done_on_last_id", {26'd0, writedata[31:26]}, 32'(NUM_IDS));
            end
        end
    end

    // Caller sits just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] w);
        cmd_valid = 1'b1;
        cmd_data  = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        fail_timeout("send");
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        fail_timeout(name);
    endtask

    task automatic vb_pulse();
        @(posedge clk);
        #1;
        vcount = 10'd480;
        hcount = 10'd0;
        @(posedge clk);
        #1;
        vcount = 10'd100;
        hcount = 10'd5;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] commit_w;
        logic [31:0] w;
        logic        found;
        commit_w = make_word(COMMIT_ID, ACT_TOGGLE, 3'd0, 1'b0, 13'd0);

        vecs[0] = '{32'h2402_0040, 32'h2402_2040, 1'b1};
        vecs[1] = '{32'h0440_3FFF, 32'h0440_3FFF, 1'b1};
        vecs[2] = '{32'h0000_1FFF, 32'h0, 1'b0};
        vecs[3] = '{make_word(COMMIT_ID, 4'h2, 3'd0, 1'b0, 13'd5), 32'h0, 1'b0};
        vecs[4] = '{32'hFBFF_DFFF, 32'hFBFF_FFFF, 1'b1};
        vecs[5] = '{make_word(6'd1, ACT_TOGGLE, 3'd7, 1'b0, 13'h1ABC),
                    make_word(6'd1, ACT_TOGGLE, 3'd7, 1'b1, 13'h1ABC), 1'b1};
        vecs[6] = '{32'h8000_0001, 32'h8000_2001, 1'b1};
        vecs[7] = '{make_word(6'd62, ACT_UPDATE, 3'd1, 1'b0, 13'h0AAA),
                    make_word(6'd62, ACT_UPDATE, 3'd1, 1'b1, 13'h0AAA), 1'b1};

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("rst_writedata", writedata, 32'h0);
        check("rst_front_buf", {31'd0, front_buf}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_commit_done", {31'd0, commit_done}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word latency from empty/IDLE
        exp_q.push_back(32'h2402_2040);
        send(32'h2402_0040);
        @(negedge clk); #1;
        check("latency_not_early", writedata, 32'h0);
        @(negedge clk); #1;
        check("latency_word", writedata, 32'h2402_2040);
        @(negedge clk); #1;
        check("word_held_one_cycle", writedata, 32'h0);
        @(posedge clk); #1;

        // Vector table, back to back
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].emits) exp_q.push_back(vecs[i].exp);
            send(vecs[i].cmd);
        end
        drain("table_throughput", 2);
        @(posedge clk); #1;

        // Two back-to-back commits: one broadcast per vblank
        for (int i = 1; i <= NUM_IDS; i++) exp_q.push_back(toggle_word(i, 1'b1));
        send(commit_w);
        for (int i = 1; i <= NUM_IDS; i++) exp_q.push_back(toggle_word(i, 1'b0));
        send(commit_w);
        vcount = 10'd480;
        hcount = 10'd1;
        repeat (3) @(posedge clk);
        #1;
        vcount = 10'd479;
        hcount = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        vcount = 10'd100;
        hcount = 10'd5;
        check("commit_waits_vb", 32'(exp_q.size()), 32'(2 * NUM_IDS));
        vb_pulse();
        for (int i = 0; i < 40 && exp_q.size() > NUM_IDS; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("second_commit_next_vb", 32'(exp_q.size()), 32'(NUM_IDS));
        check("b2b_front_buf_1", {31'd0, front_buf}, 32'd1);
        check("b2b_frame_count_1", {16'd0, frame_count}, 32'd1);
        check("b2b_pulses_1", 32'(n_pulses), 32'd1);
        vb_pulse();
        drain("b2b_second_bcast", 40);
        check("b2b_front_buf_0", {31'd0, front_buf}, 32'd0);
        check("b2b_frame_count_2", {16'd0, frame_count}, 32'd2);
        check("b2b_pulses_2", 32'(n_pulses), 32'd2);
        @(posedge clk); #1;

        // Fill the FIFO while waiting for vblank, then push against a full FIFO
        for (int i = 1; i <= NUM_IDS; i++) exp_q.push_back(toggle_word(i, 1'b1));
        send(commit_w);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            exp_q.push_back(make_word(6'd3, ACT_UPDATE, 3'd1, 1'b0, 13'(k * 7 + 1)));
            send(make_word(6'd3, ACT_UPDATE, 3'd1, 1'b1, 13'(k * 7 + 1)));
        end
        @(negedge clk);
        check("full_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        w = make_word(6'd4, ACT_UPDATE, 3'd2, 1'b0, 13'h1234);
        exp_q.push_back(w);
        fork
            send(w);
            begin
                repeat (3) @(posedge clk);
                vb_pulse();
            end
        join
        drain("full_fifo_drain", 60);
        check("fill_front_buf_1", {31'd0, front_buf}, 32'd1);
        check("fill_frame_count_3", {16'd0, frame_count}, 32'd3);
        check("fill_pulses_3", 32'(n_pulses), 32'd3);
        check("fill_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a broadcast
        for (int i = 1; i <= NUM_IDS; i++) exp_q.push_back(toggle_word(i, 1'b0));
        send(commit_w);
        repeat (3) @(posedge clk);
        vb_pulse();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            if (writedata == toggle_word(5, 1'b0)) found = 1'b1;
        end
        if (!found) fail_timeout("bcast_id5");
        reset = 1'b1;
        #1;
        check("midrst_writedata", writedata, 32'h0);
        check("midrst_front_buf", {31'd0, front_buf}, 32'd0);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_frame_count", {16'd0, frame_count}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(32'h2402_2040);
        send(32'h2402_0040);
        drain("post_reset_word", 3);
        check("post_reset_no_pulse", 32'(n_pulses), 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
